// File: rtl/dpm_group_sched.sv
// dpm_group_sched: sequences one frame of N_GROUPS row groups into the DPM.
// Each group waits until the FIFO holds GROUP_ROWS rows. It is then either
// handed to the DPM (dpm_start / dpm_done handshake) or drained directly
// (byp_pop for GROUP_ROWS cycles). frame_done pulses after the last group.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   frame_start           pulse that begins a frame (accepted only in IDLE)
//   fifo_level            FIFO occupancy in rows
//   bypass_mode           drain the group instead of using the DPM (sampled per group)
//   dpm_done              DPM finished the current group
//   dpm_start             one-cycle start pulse to the DPM
//   byp_pop               FIFO pop during bypass drain
//   group_idx             current group, 0..N_GROUPS-1
//   busy                  high whenever the scheduler is not idle
//   frame_done            one-cycle end-of-frame pulse
//   err_timeout           sticky WAIT_DONE timeout flag
//
// Optional feature: define DPM_SCHED_TIMEOUT_EN to abort the frame when the
// DPM does not answer within TIMEOUT cycles. Without it, err_timeout is tied to 0.
module dpm_group_sched #(
  parameter int unsigned GROUP_ROWS = 4,
  parameter int unsigned N_GROUPS   = 9,
  parameter int unsigned LVL_W      = 6,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             bypass_mode,
  input  logic             dpm_done,
  output logic             dpm_start,
  output logic             byp_pop,
  output logic [3:0]       group_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout
);

  localparam int unsigned ROW_W = 3;
  localparam int unsigned GRP_W = 4;
  localparam int unsigned TO_W  = 8;

  localparam logic [LVL_W-1:0] ROWS_LVL = LVL_W'(GROUP_ROWS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GROUP_ROWS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_GROUPS - 1);

  // Elaboration guards: the counters are sized for these ranges.
  if (GROUP_ROWS < 1 || GROUP_ROWS > 8) begin : g_bad_rows
    $error("GROUP_ROWS must be 1..8");
  end
  if (N_GROUPS < 1 || N_GROUPS > 16) begin : g_bad_groups
    $error("N_GROUPS must be 1..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
    $error("TIMEOUT must be 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_ISSUE,
    S_WAIT_DONE,
    S_BYPASS,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [ROW_W-1:0] row_cnt, row_nx;
  logic [GRP_W-1:0] grp_nx;
  logic             start_nx, pop_nx, busy_nx, done_nx;

`ifdef DPM_SCHED_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt, to_nx;
  logic            err_q, err_nx;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_nx = state;
    row_nx   = row_cnt;
    grp_nx   = group_idx;
`ifdef DPM_SCHED_TIMEOUT_EN
    to_nx    = to_cnt;
    err_nx   = err_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nx = S_WAIT_DATA;
          grp_nx   = '0;
`ifdef DPM_SCHED_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end
      end
      S_WAIT_DATA: begin
        // bypass_mode is only looked at here, once per group
        if (fifo_level >= ROWS_LVL) begin
          row_nx   = '0;
          state_nx = bypass_mode ? S_BYPASS : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT_DONE;
`ifdef DPM_SCHED_TIMEOUT_EN
        to_nx    = '0;
`endif
      end
      S_WAIT_DONE: begin
        if (dpm_done) begin
          state_nx = S_NEXT;
        end
`ifdef DPM_SCHED_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
`endif
      end
      S_BYPASS: begin
        if (row_cnt == ROW_LAST) begin
          state_nx = S_NEXT;
        end else begin
          row_nx = row_cnt + ROW_W'(1);
        end
      end
      S_NEXT: begin
        if (group_idx == GRP_LAST) begin
          state_nx = S_DONE;
        end else begin
          grp_nx   = group_idx + GRP_W'(1);
          state_nx = S_WAIT_DATA;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // dpm_start lands one cycle after ISSUE (two cycles after data-ready);
    // the other flags follow the state they describe.
    start_nx = (state == S_ISSUE);
    pop_nx   = (state_nx == S_BYPASS);
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      group_idx  <= '0;
      dpm_start  <= 1'b0;
      byp_pop    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DPM_SCHED_TIMEOUT_EN
      to_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      row_cnt    <= row_nx;
      group_idx  <= grp_nx;
      dpm_start  <= start_nx;
      byp_pop    <= pop_nx;
      busy       <= busy_nx;
      frame_done <= done_nx;
`ifdef DPM_SCHED_TIMEOUT_EN
      to_cnt     <= to_nx;
      err_q      <= err_nx;
`endif
    end
  end

endmodule

// File: tb/tb_dpm_group_sched.sv
// Testbench for dpm_group_sched (default parameters): a cycle table for the
// first groups of a frame, then whole-frame sequences for DPM, bypass, slow
// FIFO, stray inputs, mid-frame reset and (with DPM_SCHED_TIMEOUT_EN) timeout.
module tb_dpm_group_sched;

  localparam int GR = 4;
  localparam int NG = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [5:0] fifo_level;
  logic       bypass_mode;
  logic       dpm_done;
  logic       dpm_start;
  logic       byp_pop;
  logic [3:0] group_idx;
  logic       busy;
  logic       frame_done;
  logic       err_timeout;

  logic man_done;
  logic auto_en;
  logic auto_done;
  logic [2:0] sh;

  int n_pass = 0;
  int n_chk  = 0;

  // observation counters, written only by the monitor
  int n_start = 0, n_pop = 0, n_burst = 0, n_bad = 0, n_fd = 0, run = 0;
  logic prev_pop = 1'b0;
  int start_grp [256];

  always #5 clk = ~clk;

  assign dpm_done = man_done | (auto_en & auto_done);

  dpm_group_sched dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .fifo_level  (fifo_level),
    .bypass_mode (bypass_mode),
    .dpm_done    (dpm_done),
    .dpm_start   (dpm_start),
    .byp_pop     (byp_pop),
    .group_idx   (group_idx),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  // Monitor plus a DPM model that answers a few cycles after each start.
  always @(negedge clk) begin
    if (rst) begin
      sh        <= '0;
      auto_done <= 1'b0;
    end else begin
      sh        <= {sh[1:0], dpm_start};
      auto_done <= sh[1];
      if (dpm_start) begin
        start_grp[n_start % 256] <= int'(group_idx);
        n_start <= n_start + 1;
      end
      if (byp_pop) begin
        n_pop <= n_pop + 1;
        run   <= run + 1;
        if (!prev_pop) n_burst <= n_burst + 1;
      end else begin
        if (prev_pop && run != GR) n_bad <= n_bad + 1;
        run <= 0;
      end
      prev_pop <= byp_pop;
      if (frame_done) n_fd <= n_fd + 1;
    end
  end

  typedef struct {
    logic       fs;
    logic [5:0] lvl;
    logic       byp;
    logic       done;
    logic       e_start;
    logic       e_pop;
    logic [3:0] e_grp;
    logic       e_busy;
    logic       e_fd;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_start"}, int'(dpm_start), 0);
    chk({name, "_pop"},   int'(byp_pop), 0);
    chk({name, "_grp"},   int'(group_idx), 0);
    chk({name, "_busy"},  int'(busy), 0);
    chk({name, "_fd"},    int'(frame_done), 0);
    chk({name, "_err"},   int'(err_timeout), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Waits for frame_done, then checks busy drops on the following cycle.
  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    chk({name, "_fd_seen"}, int'(seen), 1);
    chk({name, "_busy_at_fd"}, int'(busy), 1);
    step();
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_fd_one_cycle"}, int'(frame_done), 0);
  endtask

  task automatic wait_group(input string name, input int g, input bit need_start);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      step();
      if (int'(group_idx) == g && (!need_start || dpm_start)) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int b_start, b_fd, b_pop, b_burst, b_bad;

    //            fs lvl   byp done  st pop grp busy fd
    vecs[0]  = '{1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 6'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 6'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0};

    rst = 1'b1; frame_start = 1'b0; fifo_level = '0; bypass_mode = 1'b0;
    man_done = 1'b0; auto_en = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // cycle table: DPM group, bypass group, stray inputs, third group start
    for (int i = 0; i < 16; i++) begin
      frame_start = vecs[i].fs;
      fifo_level  = vecs[i].lvl;
      bypass_mode = vecs[i].byp;
      man_done    = vecs[i].done;
      step();
      chk($sformatf("vec%0d_start", i), int'(dpm_start),  int'(vecs[i].e_start));
      chk($sformatf("vec%0d_pop", i),   int'(byp_pop),    int'(vecs[i].e_pop));
      chk($sformatf("vec%0d_grp", i),   int'(group_idx),  int'(vecs[i].e_grp));
      chk($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_fd", i),    int'(frame_done), int'(vecs[i].e_fd));
    end
    frame_start = 1'b0; man_done = 1'b0; bypass_mode = 1'b0;

`ifndef DPM_SCHED_TIMEOUT_EN
    // without the timeout feature WAIT_DONE waits indefinitely
    repeat (100) step();
    chk("nowait_err", int'(err_timeout), 0);
    chk("nowait_busy", int'(busy), 1);
    chk("nowait_grp", int'(group_idx), 2);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step();
    chk("nowait_resume_grp", int'(group_idx), 3);
`endif
    do_reset();

    // full DPM frame
    fifo_level = 6'd4; bypass_mode = 1'b0; auto_en = 1'b1;
    b_start = n_start; b_fd = n_fd;
    pulse_frame_start();
    wait_frame("dpm");
    chk("dpm_starts", n_start - b_start, NG);
    for (int g = 0; g < NG; g++)
      chk($sformatf("dpm_start_grp%0d", g), start_grp[(b_start + g) % 256], g);
    chk("dpm_frame_done_cnt", n_fd - b_fd, 1);
    repeat (5) step();
    chk("dpm_grp_hold", int'(group_idx), NG - 1);
    chk("dpm_err", int'(err_timeout), 0);

    // bypass frame
    bypass_mode = 1'b1; fifo_level = 6'd8;
    b_start = n_start; b_fd = n_fd; b_pop = n_pop; b_burst = n_burst; b_bad = n_bad;
    pulse_frame_start();
    chk("byp_grp_restart", int'(group_idx), 0);
    wait_frame("byp");
    chk("byp_pops", n_pop - b_pop, NG * GR);
    chk("byp_bursts", n_burst - b_burst, NG);
    chk("byp_bad_bursts", n_bad - b_bad, 0);
    chk("byp_starts", n_start - b_start, 0);
    chk("byp_frame_done_cnt", n_fd - b_fd, 1);
    bypass_mode = 1'b0;

    // FIFO one row short for 20 cycles
    fifo_level = 6'd3;
    b_start = n_start;
    pulse_frame_start();
    repeat (20) step();
    chk("slow_no_start", n_start - b_start, 0);
    fifo_level = 6'd4;
    step();
    chk("slow_start_lat1", int'(dpm_start), 0);
    step();
    chk("slow_start_lat2", int'(dpm_start), 1);
    wait_frame("slow");
    chk("slow_starts", n_start - b_start, NG);

    // stray frame_start and dpm_done while waiting for data in group 2
    b_start = n_start; b_fd = n_fd;
    pulse_frame_start();
    wait_group("stray_reach_g2", 2, 1'b0);
    fifo_level = 6'd0;
    frame_start = 1'b1; man_done = 1'b1;
    step();
    frame_start = 1'b0; man_done = 1'b0;
    repeat (3) step();
    chk("stray_grp", int'(group_idx), 2);
    chk("stray_busy", int'(busy), 1);
    chk("stray_starts_so_far", n_start - b_start, 2);
    fifo_level = 6'd4;
    wait_frame("stray");
    chk("stray_starts", n_start - b_start, NG);
    chk("stray_frame_done_cnt", n_fd - b_fd, 1);
    chk("stray_grp_final", int'(group_idx), NG - 1);

    // reset in group 5 WAIT_DONE
    pulse_frame_start();
    wait_group("rst_reach_g5", 5, 1'b1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    step();
    step();
    rst = 1'b0;
    b_start = n_start; b_fd = n_fd; b_pop = n_pop;
    repeat (10) step();
    chk("midrst_no_start", n_start - b_start, 0);
    chk("midrst_no_fd", n_fd - b_fd, 0);
    chk("midrst_no_pop", n_pop - b_pop, 0);
    chk("midrst_idle", int'(busy), 0);
    pulse_frame_start();
    chk("midrst_new_grp", int'(group_idx), 0);
    chk("midrst_new_busy", int'(busy), 1);
    wait_frame("midrst_new");
    chk("midrst_new_starts", n_start - b_start, NG);

`ifdef DPM_SCHED_TIMEOUT_EN
    // DPM never answers
    auto_en = 1'b0; fifo_level = 6'd4;
    b_fd = n_fd;
    pulse_frame_start();
    wait_group("to_first_start", 0, 1'b1);
    repeat (63) step();
    chk("to_before_err", int'(err_timeout), 0);
    chk("to_before_busy", int'(busy), 1);
    step();
    chk("to_err", int'(err_timeout), 1);
    chk("to_idle", int'(busy), 0);
    repeat (3) step();
    chk("to_sticky", int'(err_timeout), 1);
    chk("to_no_fd", n_fd - b_fd, 0);
    pulse_frame_start();
    chk("to_cleared", int'(err_timeout), 0);
    chk("to_restart_busy", int'(busy), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
